// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: shared FSM state type, common {M,S,CN} command codes and counter sizing helper.
package alu_seq_pkg;
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   // Command codes packed as {M, S[3:0], CN}; logic ops have no carry, so CN is 0.
   localparam logic [5:0] OP_ADD  = 6'b0_0000_0;
   localparam logic [5:0] OP_SUB  = 6'b0_0001_1;
   localparam logic [5:0] OP_AND  = 6'b1_0000_0;
   localparam logic [5:0] OP_OR   = 6'b1_0001_0;
   localparam logic [5:0] OP_XOR  = 6'b1_0010_0;
   localparam logic [5:0] OP_NAND = 6'b1_0011_0;
   function automatic int cnt_w(input int n);
      return n > 1 ? $clog2(n) : 1;
   endfunction
endpackage

// File: rtl/alu_seq_ctrl.sv
// alu_seq_ctrl: IDLE/RUN/DONE sequencing FSM with the nibble counter.
module alu_seq_ctrl
   import alu_seq_pkg::*;
#(
   parameter int NIBBLES = 4,
   parameter int CW = cnt_w(NIBBLES)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          cmd_valid,
   input  logic          res_ready,
   output state_t        state,
   output logic [CW-1:0] cnt,
   output logic          last
);
   state_t state_n;
   logic [CW-1:0] cnt_n;
   assign last = cnt == CW'(NIBBLES - 1);
   always_comb begin
      state_n = state == IDLE ? (cmd_valid ? RUN : IDLE) :
                state == RUN  ? (last ? DONE : RUN) :
                                (res_ready ? IDLE : DONE);
      cnt_n = (state == RUN && !last) ? cnt + 1'b1 : '0;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
      end
   end
endmodule

// File: rtl/alu_nibble_sequencer.sv
// alu_nibble_sequencer: runs WIDTH-bit commands nibble-serially, LSB first, through one external 4-bit ALU slice.
module alu_nibble_sequencer
   import alu_seq_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [WIDTH-1:0] cmd_a,
   input  logic [WIDTH-1:0] cmd_b,
   input  logic [3:0]       cmd_s,
   input  logic             cmd_m,
   input  logic             cmd_cn,
   output logic [3:0]       alu_a,
   output logic [3:0]       alu_b,
   output logic [3:0]       alu_s,
   output logic             alu_m,
   output logic             alu_cn,
   input  logic [3:0]       alu_f,
   input  logic             alu_cout,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [WIDTH-1:0] res_f,
   output logic             res_cout
);
   localparam int NIBBLES = WIDTH / 4;
   localparam int CW = cnt_w(NIBBLES);
   state_t state;
   logic [CW-1:0] cnt;
   logic last, run;
   logic [NIBBLES-1:0][3:0] op_a, op_b, res_q;
   logic [3:0] op_s;
   logic op_m, carry;
   alu_seq_ctrl #(.NIBBLES(NIBBLES)) ctrl (
      .clk       (clk),
      .rst       (rst),
      .cmd_valid (cmd_valid),
      .res_ready (res_ready),
      .state     (state),
      .cnt       (cnt),
      .last      (last)
   );
   assign run       = state == RUN;
   assign cmd_ready = state == IDLE;
   assign res_valid = state == DONE;
   assign res_f     = res_q;
   // carry holds cmd_cn for nibble 0, then the previous nibble's carry-out.
   always_comb begin
      alu_a  = run ? op_a[cnt] : '0;
      alu_b  = run ? op_b[cnt] : '0;
      alu_s  = run ? op_s : '0;
      alu_m  = run && op_m;
      alu_cn = run && carry;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         op_a     <= '0;
         op_b     <= '0;
         op_s     <= '0;
         op_m     <= 1'b0;
         carry    <= 1'b0;
         res_q    <= '0;
         res_cout <= 1'b0;
      end else if (cmd_ready && cmd_valid) begin
         op_a     <= cmd_a;
         op_b     <= cmd_b;
         op_s     <= cmd_s;
         op_m     <= cmd_m;
         carry    <= cmd_cn;
         res_q    <= '0;
         res_cout <= 1'b0;
      end else if (run) begin
         res_q[cnt] <= alu_f;
         carry      <= alu_cout;
         if (last) res_cout <= alu_cout;
      end
   end
endmodule

// File: tb/tb_alu_nibble_sequencer.sv
// tb_alu_nibble_sequencer: directed and random commands against a full-width reference model with a 4-bit slice model attached.
module tb_alu_nibble_sequencer;
   import alu_seq_pkg::*;
   localparam int W = 16;
   localparam int N = W / 4;
   logic clk = 0, rst = 1, cmd_valid = 0, cmd_m = 0, cmd_cn = 0, res_ready = 1;
   logic [W-1:0] cmd_a = '0, cmd_b = '0;
   logic [3:0] cmd_s = '0;
   logic cmd_ready, alu_m, alu_cn, alu_cout, res_valid, res_cout;
   logic [3:0] alu_a, alu_b, alu_s, alu_f;
   logic [W-1:0] res_f;
   logic [4:0] sl_sum;
   int cyc = 0, total = 0, passes = 0;
   logic [5:0] ops [6];

   alu_nibble_sequencer #(.WIDTH(W)) dut (
      .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_s(cmd_s), .cmd_m(cmd_m), .cmd_cn(cmd_cn),
      .alu_a(alu_a), .alu_b(alu_b), .alu_s(alu_s), .alu_m(alu_m), .alu_cn(alu_cn),
      .alu_f(alu_f), .alu_cout(alu_cout), .res_valid(res_valid), .res_ready(res_ready),
      .res_f(res_f), .res_cout(res_cout)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // 4-bit slice: arithmetic A+B+CN (S[0]=0) or A+~B+CN (S[0]=1); logic AND/OR/XOR/NAND with carry forced low.
   always_comb begin
      sl_sum   = {1'b0, alu_a} + {1'b0, alu_s[0] ? ~alu_b : alu_b} + 5'(alu_cn);
      alu_f    = !alu_m ? sl_sum[3:0] :
                 alu_s[1:0] == 2'd0 ? alu_a & alu_b :
                 alu_s[1:0] == 2'd1 ? alu_a | alu_b :
                 alu_s[1:0] == 2'd2 ? alu_a ^ alu_b : ~(alu_a & alu_b);
      alu_cout = !alu_m && sl_sum[4];
   end

   function automatic logic [W:0] ref_op(input logic [W-1:0] a, b, input logic [3:0] s, input logic m, cn);
      logic [W-1:0] bs;
      bs = s[0] ? ~b : b;
      if (m) return {1'b0, s[1:0] == 2'd0 ? a & b : s[1:0] == 2'd1 ? a | b : s[1:0] == 2'd2 ? a ^ b : ~(a & b)};
      return {1'b0, a} + {1'b0, bs} + (W+1)'(cn);
   endfunction

   // Carry entering nibble k is the carry out of the low 4k bits of the full-width sum.
   function automatic logic cin_at(input logic [W-1:0] a, b, input logic [3:0] s, input logic m, cn, input int k);
      logic [W:0] mask, sum;
      if (k == 0) return cn;
      if (m) return 1'b0;
      mask = (W+1)'((1 << (4 * k)) - 1);
      sum  = ({1'b0, a} & mask) + ({1'b0, s[0] ? ~b : b} & mask) + (W+1)'(cn);
      return sum[4 * k];
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passes++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic scramble_cmd;
      cmd_a  = W'($urandom);
      cmd_b  = W'($urandom);
      cmd_s  = 4'($urandom);
      cmd_m  = 1'($urandom);
      cmd_cn = 1'($urandom);
   endtask

   task automatic do_op(input logic [W-1:0] a, b, input logic [5:0] op, input int hold);
      logic [W:0] exp;
      int e, n;
      exp = ref_op(a, b, op[4:1], op[5], op[0]);
      cmd_a = a; cmd_b = b; cmd_m = op[5]; cmd_s = op[4:1]; cmd_cn = op[0]; cmd_valid = 1;
      n = 0;
      while (!cmd_ready && n < 20) begin tick; n++; end
      chk("accept_ready", cmd_ready, 1);
      e = cyc;
      tick;
      cmd_valid = 0;
      scramble_cmd;
      for (int k = 0; k < N; k++) begin
         chk("run_cmd_ready", cmd_ready, 0);
         chk("alu_a", alu_a, a[4*k +: 4]);
         chk("alu_b", alu_b, b[4*k +: 4]);
         chk("alu_s", alu_s, op[4:1]);
         chk("alu_m", alu_m, op[5]);
         chk("alu_cn", alu_cn, cin_at(a, b, op[4:1], op[5], op[0], k));
         tick;
      end
      n = 0;
      while (!res_valid && n < 20) begin tick; n++; end
      chk("latency", cyc - e, N + 1);
      chk("res_f", res_f, exp[W-1:0]);
      chk("res_cout", res_cout, exp[W]);
      chk("done_alu_a", alu_a, 0);
      res_ready = hold == 0;
      for (int i = 0; i < hold; i++) begin
         scramble_cmd;
         cmd_valid = 1;
         tick;
         chk("bp_valid", res_valid, 1);
         chk("bp_res_f", res_f, exp[W-1:0]);
         chk("bp_res_cout", res_cout, exp[W]);
         chk("bp_cmd_ready", cmd_ready, 0);
      end
      res_ready = 1;
      tick;
      chk("post_ready", cmd_ready, 1);
      chk("post_valid", res_valid, 0);
      cmd_valid = 0;
   endtask

   initial begin
      logic [5:0] op;
      ops = '{OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NAND};
      rst = 1;
      tick;
      tick;
      chk("rst_cmd_ready", cmd_ready, 1);
      chk("rst_res_valid", res_valid, 0);
      chk("rst_res_f", res_f, 0);
      chk("rst_res_cout", res_cout, 0);
      chk("rst_alu", {alu_a, alu_b, alu_s, alu_m, alu_cn}, 0);
      rst = 0;
      tick;
      do_op(16'h00FF, 16'h0001, OP_ADD, 0);
      do_op(16'h1234, 16'h1235, OP_SUB, 0);
      do_op(16'h1235, 16'h1234, OP_SUB, 0);
      do_op(16'hFFFF, 16'h0001, OP_ADD, 0);
      do_op(16'hF0F0, 16'hFF00, OP_XOR, 0);
      do_op(16'hFFFF, 16'hFFFF, OP_NAND | 6'b1, 0);
      do_op(16'hABCD, 16'h1111, OP_ADD, 10);
      do_op(16'h8000, 16'h8000, OP_ADD, 0);
      cmd_a = 16'h5555; cmd_b = 16'h1111; cmd_s = 4'h0; cmd_m = 0; cmd_cn = 0; cmd_valid = 1;
      tick;
      cmd_valid = 0;
      tick;
      tick;
      rst = 1;
      tick;
      rst = 0;
      chk("mid_rst_cmd_ready", cmd_ready, 1);
      chk("mid_rst_res_valid", res_valid, 0);
      chk("mid_rst_res_f", res_f, 0);
      chk("mid_rst_res_cout", res_cout, 0);
      chk("mid_rst_alu", {alu_a, alu_b, alu_s, alu_m, alu_cn}, 0);
      tick;
      chk("mid_rst_idle", res_valid, 0);
      do_op(16'h0003, 16'h0004, OP_ADD, 0);
      for (int i = 0; i < 24; i++) begin
         op = ops[$urandom_range(0, 5)];
         op[0] = op[5] ? 1'b0 : 1'($urandom);
         do_op(W'($urandom), W'($urandom), op, $urandom_range(0, 2));
      end
      $display("%0d/%0d checks passed", passes, total);
      $finish;
   end
endmodule
